// File: rtl/lfsr_weight_update.sv
// lfsr_weight_update: probabilistic saturating +/-1 weight step driven by a 7-bit LFSR draw (ports: clk, rst, upd_valid/upd_ready, prob, inc, weight, hit, done; inc_cnt/dec_cnt with WUPD_STATS_EN)
module lfsr_weight_update #(
  parameter int WEIGHT_W = 3,
  parameter int W_MAX = 7,
  parameter int W_INIT = 0,
  parameter logic [6:0] LFSR_SEED = 7'h01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [6:0]          prob,
  input  logic                inc,
  output logic [WEIGHT_W-1:0] weight,
  output logic                hit,
  output logic                done
`ifdef WUPD_STATS_EN
  ,
  output logic [15:0]         inc_cnt,
  output logic [15:0]         dec_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, DRAW, APPLY} state_t;
  localparam logic [WEIGHT_W-1:0] W_MAX_V = WEIGHT_W'(W_MAX);
  localparam logic [WEIGHT_W-1:0] W_INIT_V = WEIGHT_W'(W_INIT);
  state_t state;
  logic [6:0] lfsr;
  logic [6:0] prob_q;
  logic inc_q;
  logic hit_q;
  logic [WEIGHT_W-1:0] weight_nxt;
  assign upd_ready = state == IDLE;
  always_comb weight_nxt = inc_q ? (weight >= W_MAX_V ? weight : weight + 1'b1) : (weight == '0 ? weight : weight - 1'b1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      weight <= W_INIT_V;
      lfsr <= LFSR_SEED;
      hit <= 1'b0;
      done <= 1'b0;
      prob_q <= '0;
      inc_q <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (upd_valid) begin
          prob_q <= prob;
          inc_q <= inc;
          state <= DRAW;
        end
        DRAW: begin
          hit_q <= (lfsr <= prob_q);
          lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
          state <= APPLY;
        end
        APPLY: begin
          if (hit_q) weight <= weight_nxt;
          hit <= hit_q;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef WUPD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_cnt <= '0;
      dec_cnt <= '0;
    end else if (state == APPLY && hit_q) begin
      if (inc_q) inc_cnt <= inc_cnt + {15'd0, inc_cnt != 16'hFFFF};
      else dec_cnt <= dec_cnt + {15'd0, dec_cnt != 16'hFFFF};
    end
  end
`endif
endmodule
